// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Purpose: widths, fetch FSM state encoding and the {pc, instr} packet type
//          used by fetch_unit and its hold buffer.
// Ports:   none (package).
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int WORD_BYTES   = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {pc, instr} buffer used while decode stalls
//
// Purpose: captures the instruction that was presented but not accepted, so the
//          memory read port can be released while decode applies backpressure.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   capture           load in_pc/in_instr at the next rising edge
//   release_en        entry consumed by decode; clear it
//   flush             redirect in progress; discard the entry
//   in_pc, in_instr   packet to capture
//   hold_pc, hold_instr  current buffer contents
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        release_en,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [31:0] hold_pc,
  output logic [31:0] hold_instr
);

  fetch_pkt_t pkt_q;
  fetch_pkt_t pkt_d;

  // Flush/release win over capture; the FSM never asserts them together,
  // but discarding is the safe outcome if it ever did.
  always_comb begin
    pkt_d = pkt_q;
    if (flush || release_en) begin
      pkt_d = '0;
    end else if (capture) begin
      pkt_d.pc    = in_pc;
      pkt_d.instr = in_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign hold_pc    = pkt_q.pc;
  assign hold_instr = pkt_q.instr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage in front of a 1-cycle sync-read imem
//
// Purpose: issues word-aligned fetch addresses, pairs each returned word with
//          its PC and presents it to decode over valid/ready, with a one-entry
//          hold buffer for backpressure and zero-bubble redirects.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   imem_addr                      fetch address (bits [1:0] always 0)
//   imem_rdata                     word for the address sampled last edge
//   redirect_valid, redirect_pc    branch/jump/trap redirect request
//   if_valid, if_ready             handshake to decode
//   if_pc, if_instr                presented instruction (0 when not valid)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(WORD_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            hold_capture;
  logic            hold_release;
  logic            hold_flush;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] redirect_tgt;
  logic            out_valid;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // A redirect bypasses fetch_pc so the target is read in the same cycle.
  assign imem_addr = redirect_valid ? redirect_tgt : fetch_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    hold_capture = 1'b0;
    hold_release = 1'b0;
    hold_flush   = 1'b0;

    if (redirect_valid) begin
      state_d     = FETCH;
      req_valid_d = 1'b1;
      req_pc_d    = redirect_tgt;
      fetch_pc_d  = redirect_tgt + PC_STEP;
      hold_flush  = 1'b1;
    end else if (state_q == FETCH) begin
      if (req_valid_q && !if_ready) begin
        // Park the unaccepted word; the read issued this edge is dropped and
        // fetch_pc still points at it, so it is reissued on release.
        state_d      = HOLD;
        req_valid_d  = 1'b0;
        hold_capture = 1'b1;
      end else begin
        req_valid_d = 1'b1;
        req_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + PC_STEP;
      end
    end else if (if_ready) begin
      // Held word consumed; issue the next fetch on the same edge (no bubble).
      state_d      = FETCH;
      req_valid_d  = 1'b1;
      req_pc_d     = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + PC_STEP;
      hold_release = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      fetch_pc_q  <= XLEN'(RESET_PC);
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (hold_capture),
    .release_en (hold_release),
    .flush      (hold_flush),
    .in_pc      (req_pc_q),
    .in_instr   (imem_rdata),
    .hold_pc    (hold_pc),
    .hold_instr (hold_instr)
  );

  always_comb begin
    if (state_q == FETCH) begin
      out_valid = req_valid_q & ~redirect_valid;
    end else begin
      out_valid = ~redirect_valid;
    end
  end

  always_comb begin
    if_valid = out_valid;
    if_pc    = '0;
    if_instr = '0;
    if (out_valid) begin
      if (state_q == FETCH) begin
        if_pc    = req_pc_q;
        if_instr = imem_rdata;
      end else begin
        if_pc    = hold_pc;
        if_instr = hold_instr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int errors;
  int checks;

  logic [31:0] mem [0:1023];

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous-read instruction memory; address bits above 11 alias.
  always @(posedge clk) imem_rdata <= mem[imem_addr[11:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
    check({tag, ".pc"}, if_pc, pc);
    check({tag, ".instr"}, if_instr, instr);
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled a further 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Release reset and check the start-of-fetch sequence from RESET_PC = 0.
  task automatic reset_sequence(input string tag);
    tick();
    reset = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    settle();
    check({tag, ".c1_addr"}, imem_addr, 32'h0);
    expect_out({tag, ".c1"}, 1'b0, 32'h0, 32'h0);
    tick(); settle();
    expect_out({tag, ".c2"}, 1'b1, 32'h0, 32'hDEADBEEF);
    tick(); settle();
    expect_out({tag, ".c3"}, 1'b1, 32'h4, 32'hDEAD0000);
    tick(); settle();
    expect_out({tag, ".c4"}, 1'b1, 32'h8, 32'hDEADBEEF);
    tick(); settle();
    expect_out({tag, ".c5"}, 1'b1, 32'hC, 32'h0000BEEF);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]   = 32'hDEADBEEF;
    mem[1]   = 32'hDEAD0000;
    mem[2]   = 32'hDEADBEEF;
    mem[3]   = 32'h0000BEEF;
    mem[255] = 32'hBEEFBEEF;

    reset = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    check("rst_addr", imem_addr, 32'h0);
    expect_out("rst", 1'b0, 32'h0, 32'h0);
    tick();

    // 1: start-up sequence
    reset_sequence("s1");

    // 2: backpressure on pc=4 for three cycles
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0; settle();
    tick();
    redirect_valid = 1'b0; settle();
    expect_out("s2.pc0", 1'b1, 32'h0, 32'hDEADBEEF);
    tick();
    if_ready = 1'b0; settle();
    expect_out("s2.stallA", 1'b1, 32'h4, 32'hDEAD0000);
    check("s2.stallA_addr", imem_addr, 32'h8);
    tick(); settle();
    expect_out("s2.stallB", 1'b1, 32'h4, 32'hDEAD0000);
    check("s2.stallB_addr", imem_addr, 32'h8);
    tick(); settle();
    expect_out("s2.stallC", 1'b1, 32'h4, 32'hDEAD0000);
    check("s2.stallC_addr", imem_addr, 32'h8);
    tick();
    if_ready = 1'b1; settle();
    expect_out("s2.accept", 1'b1, 32'h4, 32'hDEAD0000);
    tick(); settle();
    expect_out("s2.next", 1'b1, 32'h8, 32'hDEADBEEF);

    // 3: redirect while streaming
    redirect_valid = 1'b1; redirect_pc = 32'h3FC; settle();
    check("s3.redir_valid", {31'b0, if_valid}, 32'h0);
    check("s3.redir_addr", imem_addr, 32'h3FC);
    tick();
    redirect_valid = 1'b0; settle();
    expect_out("s3.tgt", 1'b1, 32'h3FC, 32'hBEEFBEEF);
    tick(); settle();
    expect_out("s3.tgt4", 1'b1, 32'h400, 32'h0);

    // 4: redirect while holding pc=8
    redirect_valid = 1'b1; redirect_pc = 32'h0; settle();
    tick();
    redirect_valid = 1'b0; settle();
    expect_out("s4.pc0", 1'b1, 32'h0, 32'hDEADBEEF);
    tick(); settle();
    expect_out("s4.pc4", 1'b1, 32'h4, 32'hDEAD0000);
    tick();
    if_ready = 1'b0; settle();
    expect_out("s4.pc8", 1'b1, 32'h8, 32'hDEADBEEF);
    tick(); settle();
    expect_out("s4.held", 1'b1, 32'h8, 32'hDEADBEEF);
    redirect_valid = 1'b1; redirect_pc = 32'hC; settle();
    check("s4.redir_valid", {31'b0, if_valid}, 32'h0);
    check("s4.redir_addr", imem_addr, 32'hC);
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1; settle();
    expect_out("s4.tgt", 1'b1, 32'hC, 32'h0000BEEF);
    tick(); settle();
    expect_out("s4.tgt4", 1'b1, 32'h10, 32'h0);

    // 5: misaligned redirect target and PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'h102; settle();
    check("s5.align_addr", imem_addr, 32'h100);
    tick();
    redirect_valid = 1'b0; settle();
    expect_out("s5.align", 1'b1, 32'h100, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    check("s5.wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0; settle();
    expect_out("s5.top", 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick(); settle();
    expect_out("s5.wrap", 1'b1, 32'h0, 32'hDEADBEEF);

    // 6: asynchronous reset mid-stream
    tick(); settle();
    expect_out("s6.pre", 1'b1, 32'h4, 32'hDEAD0000);
    #2;
    reset = 1'b1;
    #1;
    expect_out("s6.async", 1'b0, 32'h0, 32'h0);
    check("s6.async_addr", imem_addr, 32'h0);
    tick();
    reset_sequence("s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
